// File: rtl/latch_deserializer.sv
// Frames start + WIDTH serial bits sampled from a latch Q output into words on a valid/ready register.
// Optional even-parity bit per frame when the PARITY_EN macro is defined.
module latch_deserializer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             d_in,
    input  logic             d_en,
    input  logic             word_ready,
    input  logic             clr_overrun,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             overrun,
`ifdef PARITY_EN
    output logic             parity_err,
`endif
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`ifdef PARITY_EN
    // The full word must be held while the parity bit is awaited.
    localparam int unsigned SW = WIDTH;
`else
    // The last data bit goes straight to word_out, so one fewer stored bit suffices.
    localparam int unsigned SW = WIDTH - 1;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StParity
    } state_e;

    state_e           state_q;
    logic [SW-1:0]    shreg_q;
    logic [CW-1:0]    count_q;

    logic             last_bit;
    logic [SW-1:0]    shreg_shift;
    logic             complete;
    logic             parity_bad;
    logic [WIDTH-1:0] new_word;
    logic             load;
    logic             drop;

    always_comb begin
        last_bit    = (state_q == StShift) && d_en && (count_q == CW'(WIDTH - 1));
        shreg_shift = (shreg_q << 1) | SW'(d_in);
`ifdef PARITY_EN
        complete    = (state_q == StParity) && d_en && ((^shreg_q ^ d_in) == 1'b0);
        parity_bad  = (state_q == StParity) && d_en && ((^shreg_q ^ d_in) == 1'b1);
        new_word    = shreg_q;
`else
        complete    = last_bit;
        parity_bad  = 1'b0;
        new_word    = {shreg_q, d_in};
`endif
        load        = complete && (!word_valid || word_ready);
        drop        = complete && word_valid && !word_ready;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            count_q    <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    // Start bit is consumed here and never stored.
                    if (d_en && d_in) begin
                        state_q <= StShift;
                        count_q <= '0;
                    end
                end
                StShift: begin
                    if (d_en) begin
                        shreg_q <= shreg_shift;
                        if (last_bit) begin
                            count_q <= '0;
`ifdef PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StIdle;
`endif
                        end else begin
                            count_q <= count_q + CW'(1);
                        end
                    end
                end
                StParity: begin
                    if (d_en) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (load) begin
                word_out   <= new_word;
                word_valid <= 1'b1;
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end

            // A new drop on the same edge as a clear leaves overrun set.
            if (clr_overrun) begin
                overrun <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end
`ifdef PARITY_EN
            parity_err <= parity_bad;
`endif
        end
    end

    assign busy = (state_q != StIdle);

`ifndef PARITY_EN
    logic unused_parity;
    assign unused_parity = parity_bad;
`endif

endmodule

// File: tb/tb_latch_deserializer.sv
// Directed bench for latch_deserializer: scoreboard of expected words plus immediate-assertion checks.
module tb_latch_deserializer;

    localparam int unsigned W = 8;

    logic         clock;
    logic         reset;
    logic         d_in;
    logic         d_en;
    logic         word_ready;
    logic         clr_overrun;
    logic [W-1:0] word_out;
    logic         word_valid;
    logic         overrun;
    logic         busy;
`ifdef PARITY_EN
    logic         parity_err;
`endif

    int           n_checks = 0;
    int           n_fails  = 0;
    logic         ready_lvl = 1'b1;
    logic [W-1:0] exp_q[$];

    latch_deserializer #(.WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .d_in       (d_in),
        .d_en       (d_en),
        .word_ready (word_ready),
        .clr_overrun(clr_overrun),
        .word_out   (word_out),
        .word_valid (word_valid),
        .overrun    (overrun),
`ifdef PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_word(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, 32'(word_valid), 32'd1);
            check({tag, "_word"}, 32'(word_out), 32'(e));
        end
    endtask

    // Start bit, W data bits MSB first, then (with parity) the even-parity bit.
    // Settings rdy_last/clr_last apply only on the completing edge.
    task automatic send_frame(input logic [W-1:0] w, input logic rdy_last, input logic clr_last,
                              input int gap_at, input logic bad_par);
        logic [W:0] bits;
        int         n;
        bits = {w, (^w) ^ bad_par};
`ifdef PARITY_EN
        n = W + 1;
`else
        n = W;
`endif
        d_en = 1'b1;
        d_in = 1'b1;
        tick();
        check("busy_after_start", 32'(busy), 32'd1);
        for (int k = 0; k < n; k++) begin
            if (k == gap_at) begin
                for (int g = 0; g < 3; g++) begin
                    d_en = 1'b0;
                    d_in = ~d_in;
                    tick();
                    check("gap_busy", 32'(busy), 32'd1);
                end
                d_en = 1'b1;
            end
            d_in = bits[W-k];
            if (k == n - 1) begin
                word_ready  = rdy_last;
                clr_overrun = clr_last;
            end
            tick();
        end
        d_en        = 1'b0;
        d_in        = 1'b0;
        word_ready  = ready_lvl;
        clr_overrun = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        d_in        = 1'b0;
        d_en        = 1'b0;
        word_ready  = 1'b1;
        clr_overrun = 1'b0;
        #2;
        check("rst_word", 32'(word_out), 32'h0);
        check("rst_valid", 32'(word_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Basic frame, valid for exactly one cycle with ready high
        exp_q.push_back(8'hB2);
        send_frame(8'hB2, 1'b1, 1'b0, -1, 1'b0);
        check_word("t2");
        tick();
        check("t2_valid_drop", 32'(word_valid), 32'd0);
        check("t2_idle", 32'(busy), 32'd0);

        // Three strobe-less cycles after the third data bit
        exp_q.push_back(8'hB2);
        send_frame(8'hB2, 1'b1, 1'b0, 3, 1'b0);
        check_word("t5");
        tick();

        // Backpressure: second frame dropped, overrun set, then cleared
        ready_lvl  = 1'b0;
        word_ready = 1'b0;
        exp_q.push_back(8'hB2);
        send_frame(8'hB2, 1'b0, 1'b0, -1, 1'b0);
        check_word("t3a");
        check("t3a_overrun", 32'(overrun), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b0, -1, 1'b0);
        check("t3b_word_held", 32'(word_out), 32'hB2);
        check("t3b_overrun", 32'(overrun), 32'd1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("t3c_overrun_clr", 32'(overrun), 32'd0);
        check("t3c_valid", 32'(word_valid), 32'd1);

        // Accept and completion on the same edge
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0, -1, 1'b0);
        check_word("t4");
        check("t4_overrun", 32'(overrun), 32'd0);
        tick();
        check("t4_held", 32'(word_valid), 32'd1);

        // Clear and new drop on the same edge: set wins
        send_frame(8'hB2, 1'b0, 1'b1, -1, 1'b0);
        check("setwin_overrun", 32'(overrun), 32'd1);
        check("setwin_word", 32'(word_out), 32'h5A);

        // Reset mid-frame between edges clears everything at once
        d_en = 1'b1;
        d_in = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            d_in = k[0];
            tick();
        end
        check("t1_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("t1_word", 32'(word_out), 32'h0);
        check("t1_valid", 32'(word_valid), 32'd0);
        check("t1_overrun", 32'(overrun), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        d_en = 1'b0;
        tick();
        reset      = 1'b0;
        ready_lvl  = 1'b1;
        word_ready = 1'b1;
        tick();
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0, -1, 1'b0);
        check_word("t1_fresh");
        tick();
        check("t1_fresh_drop", 32'(word_valid), 32'd0);

`ifdef PARITY_EN
        // 8'hB2 has four ones, so the even-parity bit is 0; flipping it must be rejected
        send_frame(8'hB2, 1'b1, 1'b0, -1, 1'b1);
        check("t6_perr", 32'(parity_err), 32'd1);
        check("t6_perr_valid", 32'(word_valid), 32'd0);
        check("t6_perr_overrun", 32'(overrun), 32'd0);
        tick();
        check("t6_perr_pulse", 32'(parity_err), 32'd0);
        exp_q.push_back(8'hB2);
        send_frame(8'hB2, 1'b1, 1'b0, -1, 1'b0);
        check_word("t6_good");
        check("t6_good_perr", 32'(parity_err), 32'd0);
        tick();
`endif

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
